// File: rtl/sram_burst_controller_if.sv
// MEM-stage side of the SRAM burst controller: one word request in, one word result out.
// `ready` low freezes the pipeline registers.
interface sram_burst_controller_if #(
  parameter int WORD_W = 32
);
  logic              write_en;
  logic              read_en;
  logic [31:0]       address;
  logic [WORD_W-1:0] writeData;
  logic [WORD_W-1:0] read_data;
  logic              ready;

  modport master (
    output write_en, read_en, address, writeData,
    input  read_data, ready
  );

  modport slave (
    input  write_en, read_en, address, writeData,
    output read_data, ready
  );
endinterface

// File: rtl/sram_burst_controller.sv
// Splits one CPU word access into WORD_W/SRAM_DW little-endian beats on an async SRAM,
// each beat held for WAIT_CYCLES+1 cycles; ready doubles as the pipeline freeze.
module sram_burst_controller #(
  parameter int WORD_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  sram_burst_controller_if.slave bus,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);
  localparam int BEATS = WORD_W / SRAM_DW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [BW-1:0]      r_beat;
  logic [WW-1:0]      r_wait;
  logic [SRAM_AW-1:0] r_base;
  logic [WORD_W-1:0]  r_wdata;
  logic [WORD_W-1:0]  r_shadow;
  logic [WORD_W-1:0]  r_rdata;
  logic               r_is_wr;

  logic               w_req;
  logic               w_accept;
  logic               w_beat_end;
  logic               w_last_beat;
  logic               w_drive;
  logic               w_ready;
  logic [SRAM_AW-1:0] w_base_nxt;
  logic [SRAM_DW-1:0] w_wslice;
  logic [WORD_W-1:0]  w_shadow_nxt;

  assign w_req = bus.read_en | bus.write_en;

  // First beat address = word index * BEATS; out-of-range wraps modulo 2^SRAM_AW.
  assign w_base_nxt = SRAM_AW'(((bus.address - 32'(BASE_ADDR)) >> 2) * 32'(BEATS));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_drive     = 1'b0;
    w_beat_end  = 1'b0;
    w_last_beat = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Combinational so the freeze lands in the request cycle itself.
        w_ready = ~w_req;
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_drive     = r_is_wr;
        w_beat_end  = (r_wait == WAIT_LAST);
        w_last_beat = w_beat_end && (r_beat == BEAT_LAST);
        if (w_last_beat) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wslice     = '0;
    w_shadow_nxt = r_shadow;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BW'(b)) begin
        w_wslice                          = r_wdata[b*SRAM_DW +: SRAM_DW];
        w_shadow_nxt[b*SRAM_DW +: SRAM_DW] = SRAM_DQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat   <= '0;
      r_wait   <= '0;
      r_base   <= '0;
      r_wdata  <= '0;
      r_is_wr  <= 1'b0;
      r_shadow <= '0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      // Write wins when both enables are up.
      r_base  <= w_base_nxt;
      r_wdata <= bus.writeData;
      r_is_wr <= bus.write_en;
      r_beat  <= '0;
      r_wait  <= '0;
    end else if (r_state == S_ACCESS) begin
      if (w_beat_end) begin
        r_wait <= '0;
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        if (!r_is_wr) begin
          r_shadow <= w_shadow_nxt;
          if (w_last_beat) r_rdata <= w_shadow_nxt;
        end
      end else begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign SRAM_DQ   = w_drive ? w_wslice : {SRAM_DW{1'bz}};
  assign SRAM_WE_N = ~w_drive;
  assign SRAM_ADDR = (r_state == S_ACCESS) ? (r_base + SRAM_AW'(r_beat)) : '0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign bus.ready     = w_ready;
  assign bus.read_data = r_rdata;
endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller: defaults, WAIT_CYCLES=0 and 64-bit word variants,
// each against a small async SRAM model; expectations queued per access and popped at ready.
module tb_sram_burst_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_burst_controller_if #(.WORD_W(32)) ifa ();
  sram_burst_controller_if #(.WORD_W(32)) ifb ();
  sram_burst_controller_if #(.WORD_W(64)) ifc ();

  wire  [15:0] dq_a, dq_b, dq_c;
  logic [17:0] ad_a, ad_b, ad_c;
  logic        we_a, we_b, we_c;
  logic [3:0]  tie_a, tie_b, tie_c;

  sram_burst_controller u_a (
    .clk(clk), .rst(rst), .bus(ifa), .SRAM_DQ(dq_a), .SRAM_ADDR(ad_a), .SRAM_WE_N(we_a),
    .SRAM_UB_N(tie_a[0]), .SRAM_LB_N(tie_a[1]), .SRAM_CE_N(tie_a[2]), .SRAM_OE_N(tie_a[3]));

  sram_burst_controller #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .bus(ifb), .SRAM_DQ(dq_b), .SRAM_ADDR(ad_b), .SRAM_WE_N(we_b),
    .SRAM_UB_N(tie_b[0]), .SRAM_LB_N(tie_b[1]), .SRAM_CE_N(tie_b[2]), .SRAM_OE_N(tie_b[3]));

  sram_burst_controller #(.WORD_W(64)) u_c (
    .clk(clk), .rst(rst), .bus(ifc), .SRAM_DQ(dq_c), .SRAM_ADDR(ad_c), .SRAM_WE_N(we_c),
    .SRAM_UB_N(tie_c[0]), .SRAM_LB_N(tie_c[1]), .SRAM_CE_N(tie_c[2]), .SRAM_OE_N(tie_c[3]));

  // Async SRAM models: OE/CE tied active, so the part drives DQ whenever WE_N is high.
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] mem_c [16];
  assign dq_a = we_a ? mem_a[ad_a[3:0]] : 16'hzzzz;
  assign dq_b = we_b ? mem_b[ad_b[3:0]] : 16'hzzzz;
  assign dq_c = we_c ? mem_c[ad_c[3:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_a) mem_a[ad_a[3:0]] <= dq_a;
  always @(posedge clk) if (!we_b) mem_b[ad_b[3:0]] <= dq_b;
  always @(posedge clk) if (!we_c) mem_c[ad_c[3:0]] <= dq_c;

  typedef struct {
    int          lat;
    int          we;
    logic [17:0] a0;
    logic [63:0] rd;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [63:0] d);
    case (u)
      0: begin ifa.write_en = wr; ifa.read_en = rd; ifa.address = a; ifa.writeData = d[31:0]; end
      1: begin ifb.write_en = wr; ifb.read_en = rd; ifb.address = a; ifb.writeData = d[31:0]; end
      default: begin ifc.write_en = wr; ifc.read_en = rd; ifc.address = a; ifc.writeData = d; end
    endcase
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? ifa.ready : (u == 1) ? ifb.ready : ifc.ready;
  endfunction

  function automatic logic wen(input int u);
    return (u == 0) ? we_a : (u == 1) ? we_b : we_c;
  endfunction

  function automatic logic [17:0] sadr(input int u);
    return (u == 0) ? ad_a : (u == 1) ? ad_b : ad_c;
  endfunction

  function automatic logic [63:0] rdat(input int u);
    return (u == 0) ? {32'h0, ifa.read_data} : (u == 1) ? {32'h0, ifb.read_data} : ifc.read_data;
  endfunction

  // Called at posedge+1 of the cycle the request is first presented (cycle 0).
  // Returns in the cycle ready rises; drop_at >= 0 pulls the request mid-access.
  task automatic access(input int u, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [63:0] d, input int lat, input logic [17:0] a0,
                        input logic [63:0] exp_rd, input string tag, input int drop_at);
    exp_t e, g;
    int n, wl;
    logic [17:0] fa;
    e.lat = lat; e.we = wr ? lat - 1 : 0; e.a0 = a0; e.rd = exp_rd; e.tag = tag;
    sb.push_back(e);
    drive(u, wr, rd, a, d);
    #1;
    n = 0; wl = 0; fa = '0;
    while (!rdy(u) && n < 40) begin
      if (!wen(u)) wl++;
      if (n == 1) fa = sadr(u);
      if (n == drop_at) drive(u, 1'b0, 1'b0, 32'hFFFF_FFF0, '1);
      step();
      n++;
    end
    if (!wen(u)) wl++;
    g = sb.pop_front();
    chk({g.tag, "/latency"}, 64'(n), 64'(g.lat));
    chk({g.tag, "/we_cycles"}, 64'(wl), 64'(g.we));
    chk({g.tag, "/first_addr"}, 64'(fa), 64'(g.a0));
    chk({g.tag, "/read_data"}, rdat(u), g.rd);
  endtask

  task automatic idle(input int u);
    drive(u, 1'b0, 1'b0, 32'h0, 64'h0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 64'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 64'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset/ready", 64'(ifa.ready), 64'h1);
    chk("reset/we_n", 64'(we_a), 64'h1);
    chk("reset/addr", 64'(ad_a), 64'h0);
    chk("reset/read_data", rdat(0), 64'h0);
    chk("reset/read_data_c", rdat(2), 64'h0);
    chk("reset/tied_pins", 64'({tie_a, tie_b, tie_c}), 64'h0);

    access(0, 1'b1, 1'b0, 32'd1024, 64'hDEADBEEF, 5, 18'h0, 64'h0, "wr_base", -1);
    idle(0);
    chk("wr_base/mem0", 64'(mem_a[0]), 64'hBEEF);
    chk("wr_base/mem1", 64'(mem_a[1]), 64'hDEAD);

    // Store data of all ones on reads: any controller drive would corrupt the returned word.
    access(0, 1'b0, 1'b1, 32'd1024, '1, 5, 18'h0, 64'hDEADBEEF, "rd_base", -1);
    idle(0);
    chk("rd_base/held", rdat(0), 64'hDEADBEEF);

    access(0, 1'b1, 1'b0, 32'd1028, 64'h12345678, 5, 18'h2, 64'hDEADBEEF, "wr_map", -1);
    idle(0);
    chk("wr_map/mem2", 64'(mem_a[2]), 64'h5678);
    chk("wr_map/mem3", 64'(mem_a[3]), 64'h1234);
    chk("wr_map/mem0", 64'(mem_a[0]), 64'hBEEF);
    chk("wr_map/mem1", 64'(mem_a[1]), 64'hDEAD);

    access(0, 1'b1, 1'b1, 32'd1032, 64'hCAFEF00D, 5, 18'h4, 64'hDEADBEEF, "collide", -1);
    idle(0);
    chk("collide/mem4", 64'(mem_a[4]), 64'hF00D);
    chk("collide/mem5", 64'(mem_a[5]), 64'hCAFE);

    access(0, 1'b1, 1'b0, 32'd1036, 64'h0BADC0DE, 5, 18'h6, 64'hDEADBEEF, "b2b_wr", -1);
    step();
    access(0, 1'b0, 1'b1, 32'd1036, '1, 5, 18'h6, 64'h0BADC0DE, "b2b_rd", -1);
    idle(0);

    access(0, 1'b1, 1'b0, 32'd1020, 64'h55AA33CC, 5, 18'h3FFFE, 64'h0BADC0DE, "wrap", -1);
    idle(0);
    chk("wrap/mem14", 64'(mem_a[14]), 64'h33CC);
    chk("wrap/mem15", 64'(mem_a[15]), 64'h55AA);

    access(0, 1'b1, 1'b0, 32'd1040, 64'h0F0F1E1E, 5, 18'h8, 64'h0BADC0DE, "drop", 2);
    step();
    chk("drop/ready_idle", 64'(ifa.ready), 64'h1);
    chk("drop/mem8", 64'(mem_a[8]), 64'h1E1E);
    chk("drop/mem9", 64'(mem_a[9]), 64'h0F0F);

    access(1, 1'b1, 1'b0, 32'd1024, 64'h7E577E57, 3, 18'h0, 64'h0, "w0_wr", -1);
    idle(1);
    access(1, 1'b0, 1'b1, 32'd1024, '1, 3, 18'h0, 64'h7E577E57, "w0_rd", -1);
    idle(1);

    access(2, 1'b1, 1'b0, 32'd1028, 64'h0123456789ABCDEF, 9, 18'h4, 64'h0, "w64_wr", -1);
    idle(2);
    chk("w64_wr/mem4", 64'(mem_c[4]), 64'hCDEF);
    chk("w64_wr/mem5", 64'(mem_c[5]), 64'h89AB);
    chk("w64_wr/mem6", 64'(mem_c[6]), 64'h4567);
    chk("w64_wr/mem7", 64'(mem_c[7]), 64'h0123);
    access(2, 1'b0, 1'b1, 32'd1028, '1, 9, 18'h4, 64'h0123456789ABCDEF, "w64_rd", -1);
    idle(2);

    // Reset lands at the end of cycle 2: beat 0 is written, beat 1 never starts.
    drive(0, 1'b1, 1'b0, 32'd1024, 64'h11112222);
    #1;
    chk("rst_mid/ready_c0", 64'(ifa.ready), 64'h0);
    step();
    step();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 64'h0);
    step();
    chk("rst_mid/we_n", 64'(we_a), 64'h1);
    chk("rst_mid/addr", 64'(ad_a), 64'h0);
    chk("rst_mid/ready", 64'(ifa.ready), 64'h1);
    chk("rst_mid/read_data", rdat(0), 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_mid/mem0", 64'(mem_a[0]), 64'h2222);
    chk("rst_mid/mem1", 64'(mem_a[1]), 64'hDEAD);
    access(0, 1'b0, 1'b1, 32'd1024, '1, 5, 18'h0, 64'hDEAD2222, "rd_after_rst", -1);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
- Parametrised successor to the pipeline's fixed-width SRAM controller.
- Bridges one MEM-stage word access (read or write) onto a narrower external asynchronous SRAM as a multi-beat sequence.
- Each beat has a configurable wait-state count.
- `ready` is the pipeline freeze source: the core freezes IF/ID/EXE/MEM registers while it is low.

Parameters:
- WORD_W, 32: CPU word width; must be an integer multiple of SRAM_DW.
- SRAM_DW, 16: external SRAM data width.
- SRAM_AW, 18: external SRAM address width.
- WAIT_CYCLES, 1: extra hold cycles per beat, ≥0; each beat lasts WAIT_CYCLES+1 cycles.
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- write_en  in  1  store request, level, held by the MEM stage until done.
- read_en  in  1  load request, level, held until done.
- address  in  32  CPU byte address (ALU result).
- writeData  in  WORD_W  store data.
- read_data  out  WORD_W  load result, valid in the DONE cycle and held until the next read completes.
- ready  out  1  high = no pending access / access complete.
- SRAM_DQ  inout  SRAM_DW  bidirectional data.
- SRAM_ADDR  out  SRAM_AW  SRAM word address.
- SRAM_WE_N  out  1  active-low write enable.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.

Behaviour:
- Derived constants:
  - BEATS = WORD_W/SRAM_DW.
  - BEAT_LEN = WAIT_CYCLES+1.
- Latched word index: wi = (address − BASE_ADDR) >> 2, captured at request acceptance.
- Beat addressing: beat b (0..BEATS−1) drives SRAM_ADDR = (wi*BEATS + b) truncated to SRAM_AW.
- Byte order is little-endian: beat b carries data bits [b*SRAM_DW +: SRAM_DW].
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - ready = ~(read_en | write_en), which is combinational so the freeze takes effect in the request cycle itself.
  - On a request, latch wi, writeData and op, then go to ACCESS with beat=0, wait=0.
  - If both enables are high, the op is a write (write priority).
- ACCESS:
  - ready = 0.
  - wait counts 0..WAIT_CYCLES. At wait == WAIT_CYCLES the beat ends:
    - For a read, capture SRAM_DQ into the beat's slice of the read_data shadow register.
    - Then increment beat and clear wait.
  - When the last beat ends, go to DONE.
- DONE:
  - ready = 1 for exactly one cycle; read_data is updated from the shadow in this cycle.
  - The pipeline advances on this edge; next state is IDLE.
  - A new request presented in the following cycle is serviced normally, with no dead cycle beyond IDLE.
- Latency: with the request first seen in cycle 0, ready = 1 in cycle BEATS*BEAT_LEN+1.
  - Defaults give cycle 5.
  - WAIT_CYCLES=0 gives cycle 3.
- SRAM pin behaviour:
  - SRAM_WE_N = 0 only in ACCESS during a write, for all cycles of each beat; otherwise 1.
  - SRAM_DQ is driven with the beat slice only in ACCESS during a write; otherwise high-Z.
  - SRAM_ADDR is the current beat address in ACCESS; 0 otherwise.
- Requests are not re-sampled during ACCESS/DONE: address and data changes mid-access are ignored.
  - Dropping both enables mid-access does not abort; the access completes.
- Reset values:
  - state = IDLE, beat = 0, wait = 0.
  - read_data = 0, shadow = 0.
  - SRAM_WE_N = 1, SRAM_DQ = Z, SRAM_ADDR = 0.
- Reset mid-access: abandon the access; nothing further is written; the state is IDLE on the next cycle.
- Out-of-range addresses (below BASE_ADDR or beyond SRAM) wrap modulo 2^SRAM_AW, with no error reported.
- Low two address bits are ignored (word accesses only).

Test Plan:
- Write, defaults: write 32'hDEADBEEF at 1024 → ready low in cycles 0–4, high in cycle 5; SRAM[0]=16'hBEEF, SRAM[1]=16'hDEAD; WE_N low for exactly 4 cycles.
- Read back: read at 1024 → read_data=32'hDEADBEEF with ready=1 in cycle 5; DQ never driven by the controller.
- Address mapping: write 32'h12345678 at 1028 → SRAM[2]=16'h5678, SRAM[3]=16'h1234; SRAM[0..1] unchanged.
- Parameter sweep:
  - WAIT_CYCLES=0: read completes with ready high in cycle 3.
  - WORD_W=64, SRAM_DW=16: 4 beats at addresses wi*4..wi*4+3; ready high in cycle 9.
- Collisions: read_en and write_en both high → write performed, read_data unchanged. Back-to-back write-then-read → second access starts in the cycle after DONE.
- Reset mid-write: rst asserted in cycle 2 (beat 0 done, beat 1 pending) → SRAM[0] written, SRAM[1] unchanged, WE_N=1 and DQ=Z from the next cycle, ready=~request afterwards.
